// File: rtl/buffer_seq_pkg.sv
// Shared types and constants for the Zorro buffer sequencer and its helpers.
package buffer_seq_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SETUP   = 3'd1,
    DRIVE   = 3'd2,
    LATCH   = 3'd3,
    RELEASE = 3'd4
  } state_e;

  typedef enum logic {
    CYC_MASTER = 1'b0,
    CYC_SLAVE  = 1'b1
  } cyc_e;

  localparam logic DIR_TO_LOCAL = 1'b0;
  localparam logic DIR_TO_ZORRO = 1'b1;

  localparam state_e RST_STATE     = IDLE;
  localparam logic   RST_DIR       = DIR_TO_LOCAL;
  localparam logic   RST_DIR_PIN_N = 1'b1;
  localparam logic   RST_DBLT      = 1'b0;
  localparam logic   RST_BUSY      = 1'b0;

  // Data flows toward Zorro when we answer a read as slave or write as master.
  function automatic logic to_zorro(input logic master, input logic slave, input logic read);
    return (slave & read) | (master & ~read);
  endfunction

endpackage

// File: rtl/seq_down_counter.sv
// Loadable saturating down counter with a zero flag; used for the turnaround
// dead time and the optional bus watchdog.
module seq_down_counter #(
  parameter int W = 4
) (
  input  logic         CLK,
  input  logic         RESET_n,
  input  logic         load_i,
  input  logic [W-1:0] value_i,
  input  logic         dec_i,
  output logic         zero_o
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = value_i;
    end else if (dec_i && (count_q != '0)) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RESET_n) begin
    if (!RESET_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero_o = (count_q == '0);

endmodule

// File: rtl/buffer_sequencer.sv
// Zorro data/address transceiver sequencer with direction dead time and latch phase.
// Optional bus watchdog enabled by defining BUFFER_SEQ_WATCHDOG_EN.
module buffer_sequencer
  import buffer_seq_pkg::*;
#(
  parameter int                     LANES             = 4,
  parameter int                     ADDR_GROUPS       = 2,
  parameter logic [ADDR_GROUPS-1:0] ADDR_RELEASE_MASK = 2'b10,
  parameter int                     TURN_CYC          = 2,
  parameter int                     TIMEOUT_CYC       = 255
) (
  input  logic                   CLK,
  input  logic                   RESET_n,
  input  logic                   READ,
  input  logic                   FCS_n,
  input  logic                   DOE,
  input  logic                   DTACK_n,
  input  logic                   MYBUS,
  input  logic                   MASTER_n,
  input  logic                   SLAVE_n,
  input  logic [LANES-1:0]       LANE_EN,
  output logic [LANES-1:0]       DBOE_n,
  output logic [ADDR_GROUPS-1:0] ABOE_n,
  output logic                   D2Z_n,
  output logic                   Z2D_n,
  output logic                   DBLT,
  output logic                   BUSY,
  output logic                   TIMEOUT
);

  if (TURN_CYC < 0 || TURN_CYC > 15 || TIMEOUT_CYC < 1 || TIMEOUT_CYC > 255) begin : g_param_check
    $error("buffer_sequencer: TURN_CYC must be 0..15 and TIMEOUT_CYC 1..255");
  end

  localparam logic [3:0] TURN_LOAD = 4'(TURN_CYC);

  logic master, slave, start, to_z, qual_ok, abort;

  state_e           state_q, state_d;
  logic             dir_q, dir_d;
  logic             last_dir_q, last_dir_d;
  logic [LANES-1:0] lane_q, lane_d;
  cyc_e             cyc_q, cyc_d;

  logic       turn_load, turn_dec, turn_zero;
  logic [3:0] turn_val;
  logic       wd_load, wd_fire, wd_block;

  logic [LANES-1:0]       dboe_q, dboe_d;
  logic [ADDR_GROUPS-1:0] aboe_q, aboe_d;
  logic                   d2z_q, d2z_d, z2d_q, z2d_d;
  logic                   dblt_q, dblt_d, busy_q, busy_d;

  assign master  = MYBUS & ~MASTER_n & SLAVE_n;
  assign slave   = ~MYBUS & MASTER_n & ~SLAVE_n;
  assign start   = (master | slave) & ~FCS_n;
  assign to_z    = to_zorro(master, slave, READ);
  assign qual_ok = (cyc_q == CYC_MASTER) ? master : slave;
  assign abort   = FCS_n | ~qual_ok;

  seq_down_counter #(.W(4)) u_turn_cnt (
    .CLK     (CLK),
    .RESET_n (RESET_n),
    .load_i  (turn_load),
    .value_i (turn_val),
    .dec_i   (turn_dec),
    .zero_o  (turn_zero)
  );

`ifdef BUFFER_SEQ_WATCHDOG_EN
  localparam logic [7:0] WD_LOAD = 8'(TIMEOUT_CYC - 1);

  logic wd_zero, wd_active;
  logic wd_block_q, wd_block_d;
  logic timeout_q;

  assign wd_active = (state_q == DRIVE) || (state_q == LATCH);
  assign wd_fire   = wd_active & wd_zero;
  assign wd_block  = wd_block_q;

  // Loaded with limit-1 on DRIVE entry so the fire lands TIMEOUT_CYC edges later.
  seq_down_counter #(.W(8)) u_wd_cnt (
    .CLK     (CLK),
    .RESET_n (RESET_n),
    .load_i  (wd_load),
    .value_i (WD_LOAD),
    .dec_i   (wd_active),
    .zero_o  (wd_zero)
  );

  always_comb begin
    wd_block_d = wd_block_q;
    if (wd_fire) begin
      wd_block_d = 1'b1;
    end else if (FCS_n) begin
      wd_block_d = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge RESET_n) begin
    if (!RESET_n) begin
      wd_block_q <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      wd_block_q <= wd_block_d;
      timeout_q  <= wd_fire;
    end
  end

  assign TIMEOUT = timeout_q;
`else
  assign wd_fire  = 1'b0;
  assign wd_block = 1'b0;
  assign TIMEOUT  = 1'b0;
`endif

  always_ff @(posedge CLK or negedge RESET_n) begin
    if (!RESET_n) begin
      state_q    <= RST_STATE;
      dir_q      <= RST_DIR;
      last_dir_q <= RST_DIR;
      lane_q     <= '0;
      cyc_q      <= CYC_MASTER;
    end else begin
      state_q    <= state_d;
      dir_q      <= dir_d;
      last_dir_q <= last_dir_d;
      lane_q     <= lane_d;
      cyc_q      <= cyc_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    dir_d      = dir_q;
    last_dir_d = last_dir_q;
    lane_d     = lane_q;
    cyc_d      = cyc_q;
    turn_load  = 1'b0;
    turn_val   = 4'd0;
    turn_dec   = 1'b0;
    wd_load    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start && !wd_block) begin
          state_d   = SETUP;
          dir_d     = to_z;
          lane_d    = LANE_EN;
          cyc_d     = master ? CYC_MASTER : CYC_SLAVE;
          turn_load = 1'b1;
          turn_val  = (to_z != last_dir_q) ? TURN_LOAD : 4'd0;
        end
      end
      SETUP: begin
        if (abort) begin
          state_d = RELEASE;
        end else if (turn_zero) begin
          state_d = DRIVE;
          wd_load = 1'b1;
        end else begin
          turn_dec = 1'b1;
        end
      end
      DRIVE: begin
        if (abort || wd_fire) begin
          state_d = RELEASE;
        end else if (!DTACK_n && DOE) begin
          state_d = LATCH;
        end
      end
      LATCH: begin
        if (abort || wd_fire) begin
          state_d = RELEASE;
        end
      end
      RELEASE: begin
        last_dir_d = dir_q;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are decoded from the state being entered, then registered.
  always_comb begin
    dboe_d = '1;
    d2z_d  = RST_DIR_PIN_N;
    z2d_d  = RST_DIR_PIN_N;
    dblt_d = RST_DBLT;
    busy_d = (state_d != IDLE);
    if (state_d != IDLE) begin
      if (dir_d == DIR_TO_ZORRO) begin
        d2z_d = 1'b0;
      end else begin
        z2d_d = 1'b0;
      end
    end
    if ((state_d == DRIVE) || (state_d == LATCH)) begin
      if ((dir_d != DIR_TO_ZORRO) || DOE) begin
        dboe_d = ~lane_d;
      end
    end
    if (state_d == LATCH) begin
      dblt_d = 1'b1;
    end
  end

  for (genvar gi = 0; gi < ADDR_GROUPS; gi++) begin : g_aboe
    assign aboe_d[gi] = ADDR_RELEASE_MASK[gi] & master & ~FCS_n;
  end

  always_ff @(posedge CLK or negedge RESET_n) begin
    if (!RESET_n) begin
      dboe_q <= '1;
      aboe_q <= '0;
      d2z_q  <= RST_DIR_PIN_N;
      z2d_q  <= RST_DIR_PIN_N;
      dblt_q <= RST_DBLT;
      busy_q <= RST_BUSY;
    end else begin
      dboe_q <= dboe_d;
      aboe_q <= aboe_d;
      d2z_q  <= d2z_d;
      z2d_q  <= z2d_d;
      dblt_q <= dblt_d;
      busy_q <= busy_d;
    end
  end

  assign DBOE_n = dboe_q;
  assign ABOE_n = aboe_q;
  assign D2Z_n  = d2z_q;
  assign Z2D_n  = z2d_q;
  assign DBLT   = dblt_q;
  assign BUSY   = busy_q;

endmodule

// File: tb/tb_buffer_sequencer.sv
// Directed bench for buffer_sequencer; output vector is
// {DBOE_n[3:0], ABOE_n[1:0], D2Z_n, Z2D_n, DBLT, BUSY, TIMEOUT}.
module tb_buffer_sequencer;

  logic       CLK = 1'b0;
  logic       RESET_n, READ, FCS_n, DOE, DTACK_n, MYBUS, MASTER_n, SLAVE_n;
  logic [3:0] LANE_EN;
  logic [3:0] DBOE_n;
  logic [1:0] ABOE_n;
  logic       D2Z_n, Z2D_n, DBLT, BUSY, TIMEOUT;

  int errors = 0;
  int checks = 0;

  wire [10:0] outs = {DBOE_n, ABOE_n, D2Z_n, Z2D_n, DBLT, BUSY, TIMEOUT};

  localparam logic [10:0] V_IDLE = 11'b1111_00_11_000;

  buffer_sequencer #(.TIMEOUT_CYC(8)) dut (
    .CLK(CLK), .RESET_n(RESET_n), .READ(READ), .FCS_n(FCS_n), .DOE(DOE),
    .DTACK_n(DTACK_n), .MYBUS(MYBUS), .MASTER_n(MASTER_n), .SLAVE_n(SLAVE_n),
    .LANE_EN(LANE_EN), .DBOE_n(DBOE_n), .ABOE_n(ABOE_n), .D2Z_n(D2Z_n),
    .Z2D_n(Z2D_n), .DBLT(DBLT), .BUSY(BUSY), .TIMEOUT(TIMEOUT)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic bus_idle();
    READ = 0; FCS_n = 1; DOE = 0; DTACK_n = 1;
    MYBUS = 0; MASTER_n = 1; SLAVE_n = 1; LANE_EN = 4'b0000;
  endtask

  task automatic go_slave(input logic rd, input logic [3:0] lanes);
    MYBUS = 0; MASTER_n = 1; SLAVE_n = 0; READ = rd; LANE_EN = lanes; FCS_n = 0;
  endtask

  task automatic test_reset();
    logic [10:0] e;
    bus_idle();
    RESET_n = 1'b1;
    #2 RESET_n = 1'b0;
    #1;
    e = V_IDLE; checks++; if (outs !== e) begin errors++; $display("FAIL reset_async got=%b exp=%b", outs, e); end
    tick(); tick();
    checks++; if (outs !== e) begin errors++; $display("FAIL reset_held got=%b exp=%b", outs, e); end
    RESET_n = 1'b1;
    tick();
    checks++; if (outs !== e) begin errors++; $display("FAIL reset_release got=%b exp=%b", outs, e); end
    $display("reset: outputs=%b", outs);
  endtask

  task automatic test_slave_read();
    logic [10:0] e;
    go_slave(1'b1, 4'b1111);
    tick(); e = 11'b1111_00_01_010;
    checks++; if (outs !== e) begin errors++; $display("FAIL rd_setup0 got=%b exp=%b", outs, e); end
    tick();
    checks++; if (outs !== e) begin errors++; $display("FAIL rd_setup1 got=%b exp=%b", outs, e); end
    tick();
    checks++; if (outs !== e) begin errors++; $display("FAIL rd_setup2 got=%b exp=%b", outs, e); end
    DOE = 1;
    tick(); e = 11'b0000_00_01_010;
    checks++; if (outs !== e) begin errors++; $display("FAIL rd_drive got=%b exp=%b", outs, e); end
    DTACK_n = 0;
    tick(); e = 11'b0000_00_01_110;
    checks++; if (outs !== e) begin errors++; $display("FAIL rd_latch got=%b exp=%b", outs, e); end
    DTACK_n = 1; FCS_n = 1;
    tick(); e = 11'b1111_00_01_010;
    checks++; if (outs !== e) begin errors++; $display("FAIL rd_release got=%b exp=%b", outs, e); end
    tick(); e = V_IDLE;
    checks++; if (outs !== e) begin errors++; $display("FAIL rd_idle got=%b exp=%b", outs, e); end
    bus_idle();
    $display("slave read: done, outputs=%b", outs);
  endtask

  task automatic test_back_to_back();
    logic [10:0] e;
    go_slave(1'b0, 4'b1111);
    tick(); e = 11'b1111_00_10_010;
    checks++; if (outs !== e) begin errors++; $display("FAIL b2b_w1_setup got=%b exp=%b", outs, e); end
    tick(); tick(); tick(); e = 11'b0000_00_10_010;
    checks++; if (outs !== e) begin errors++; $display("FAIL b2b_w1_drive got=%b exp=%b", outs, e); end
    DOE = 1; DTACK_n = 0;
    tick(); e = 11'b0000_00_10_110;
    checks++; if (outs !== e) begin errors++; $display("FAIL b2b_w1_latch got=%b exp=%b", outs, e); end
    FCS_n = 1; DOE = 0; DTACK_n = 1;
    tick(); e = 11'b1111_00_10_010;
    checks++; if (outs !== e) begin errors++; $display("FAIL b2b_w1_release got=%b exp=%b", outs, e); end
    FCS_n = 0; LANE_EN = 4'b0101;
    tick(); e = V_IDLE;
    checks++; if (outs !== e) begin errors++; $display("FAIL b2b_gap_idle got=%b exp=%b", outs, e); end
    tick(); e = 11'b1111_00_10_010;
    checks++; if (outs !== e) begin errors++; $display("FAIL b2b_w2_setup got=%b exp=%b", outs, e); end
    tick(); e = 11'b1010_00_10_010;
    checks++; if (outs !== e) begin errors++; $display("FAIL b2b_w2_drive_nodead got=%b exp=%b", outs, e); end
    DOE = 1; DTACK_n = 0;
    tick(); e = 11'b1010_00_10_110;
    checks++; if (outs !== e) begin errors++; $display("FAIL b2b_w2_latch got=%b exp=%b", outs, e); end
    FCS_n = 1;
    tick(); tick(); e = V_IDLE;
    checks++; if (outs !== e) begin errors++; $display("FAIL b2b_w2_idle got=%b exp=%b", outs, e); end
    bus_idle();
    $display("back to back writes: done, outputs=%b", outs);
  endtask

  task automatic test_master_write();
    logic [10:0] e;
    MYBUS = 1; MASTER_n = 0; SLAVE_n = 1; READ = 0; LANE_EN = 4'b0011; FCS_n = 0;
    tick(); e = 11'b1111_10_01_010;
    checks++; if (outs !== e) begin errors++; $display("FAIL mw_setup got=%b exp=%b", outs, e); end
    tick(); tick(); tick();
    checks++; if (outs !== e) begin errors++; $display("FAIL mw_drive_doe0 got=%b exp=%b", outs, e); end
    DOE = 1;
    tick(); e = 11'b1100_10_01_010;
    checks++; if (outs !== e) begin errors++; $display("FAIL mw_drive_doe1 got=%b exp=%b", outs, e); end
    DOE = 0;
    tick(); e = 11'b1111_10_01_010;
    checks++; if (outs !== e) begin errors++; $display("FAIL mw_drive_doe_drop got=%b exp=%b", outs, e); end
    DOE = 1; DTACK_n = 0;
    tick(); e = 11'b1100_10_01_110;
    checks++; if (outs !== e) begin errors++; $display("FAIL mw_latch got=%b exp=%b", outs, e); end
    FCS_n = 1;
    tick(); e = 11'b1111_00_01_010;
    checks++; if (outs !== e) begin errors++; $display("FAIL mw_release_aboe got=%b exp=%b", outs, e); end
    tick(); e = V_IDLE;
    checks++; if (outs !== e) begin errors++; $display("FAIL mw_idle got=%b exp=%b", outs, e); end
    bus_idle();
    $display("master write: done, outputs=%b", outs);
  endtask

  task automatic test_setup_abort();
    logic [10:0] e;
    go_slave(1'b1, 4'b1111); DOE = 1; DTACK_n = 0;
    tick(); e = 11'b1111_00_01_010;
    checks++; if (outs !== e) begin errors++; $display("FAIL ab_fcs_setup got=%b exp=%b", outs, e); end
    FCS_n = 1;
    tick();
    checks++; if (outs !== e) begin errors++; $display("FAIL ab_fcs_release got=%b exp=%b", outs, e); end
    tick(); e = V_IDLE;
    checks++; if (outs !== e) begin errors++; $display("FAIL ab_fcs_idle got=%b exp=%b", outs, e); end
    go_slave(1'b0, 4'b1111); DOE = 0; DTACK_n = 1;
    tick(); e = 11'b1111_00_10_010;
    checks++; if (outs !== e) begin errors++; $display("FAIL ab_qual_setup got=%b exp=%b", outs, e); end
    SLAVE_n = 1;
    tick();
    checks++; if (outs !== e) begin errors++; $display("FAIL ab_qual_release got=%b exp=%b", outs, e); end
    tick(); e = V_IDLE;
    checks++; if (outs !== e) begin errors++; $display("FAIL ab_qual_idle got=%b exp=%b", outs, e); end
    bus_idle();
    $display("setup aborts: done, outputs=%b", outs);
  endtask

  task automatic test_lane_zero();
    logic [10:0] e;
    go_slave(1'b0, 4'b0000);
    tick(); tick(); e = 11'b1111_00_10_010;
    checks++; if (outs !== e) begin errors++; $display("FAIL lz_drive got=%b exp=%b", outs, e); end
    DOE = 1; DTACK_n = 0;
    tick(); e = 11'b1111_00_10_110;
    checks++; if (outs !== e) begin errors++; $display("FAIL lz_latch got=%b exp=%b", outs, e); end
    FCS_n = 1;
    tick(); tick(); e = V_IDLE;
    checks++; if (outs !== e) begin errors++; $display("FAIL lz_idle got=%b exp=%b", outs, e); end
    bus_idle();
    $display("lane enable zero: done, outputs=%b", outs);
  endtask

  task automatic test_async_reset();
    logic [10:0] e;
    go_slave(1'b1, 4'b1111); DOE = 1;
    tick(); tick(); tick(); tick(); DTACK_n = 0;
    tick(); e = 11'b0000_00_01_110;
    checks++; if (outs !== e) begin errors++; $display("FAIL ar_latch got=%b exp=%b", outs, e); end
    #2 RESET_n = 0;
    #1 e = V_IDLE;
    checks++; if (outs !== e) begin errors++; $display("FAIL ar_immediate got=%b exp=%b", outs, e); end
    tick(); bus_idle();
    RESET_n = 1;
    tick();
    go_slave(1'b0, 4'b1111);
    tick(); e = 11'b1111_00_10_010;
    checks++; if (outs !== e) begin errors++; $display("FAIL ar_post_setup got=%b exp=%b", outs, e); end
    tick(); e = 11'b0000_00_10_010;
    checks++; if (outs !== e) begin errors++; $display("FAIL ar_lastdir_cleared got=%b exp=%b", outs, e); end
    FCS_n = 1;
    tick(); tick(); e = V_IDLE;
    checks++; if (outs !== e) begin errors++; $display("FAIL ar_idle got=%b exp=%b", outs, e); end
    bus_idle();
    $display("async reset in latch: done, outputs=%b", outs);
  endtask

`ifdef BUFFER_SEQ_WATCHDOG_EN
  task automatic test_watchdog();
    logic [10:0] e;
    go_slave(1'b0, 4'b1111);
    tick(); tick(); e = 11'b0000_00_10_010;
    checks++; if (outs !== e) begin errors++; $display("FAIL wd_drive_entry got=%b exp=%b", outs, e); end
    for (int i = 1; i < 8; i++) begin
      tick();
      checks++; if (outs !== e) begin errors++; $display("FAIL wd_drive_wait%0d got=%b exp=%b", i, outs, e); end
    end
    tick(); e = 11'b1111_00_10_011;
    checks++; if (outs !== e) begin errors++; $display("FAIL wd_fire got=%b exp=%b", outs, e); end
    tick(); e = V_IDLE;
    checks++; if (outs !== e) begin errors++; $display("FAIL wd_pulse_end got=%b exp=%b", outs, e); end
    tick(); tick();
    checks++; if (outs !== e) begin errors++; $display("FAIL wd_blocked got=%b exp=%b", outs, e); end
    FCS_n = 1;
    tick();
    FCS_n = 0;
    tick(); e = 11'b1111_00_10_010;
    checks++; if (outs !== e) begin errors++; $display("FAIL wd_unblocked got=%b exp=%b", outs, e); end
    FCS_n = 1;
    tick(); tick(); e = V_IDLE;
    checks++; if (outs !== e) begin errors++; $display("FAIL wd_idle got=%b exp=%b", outs, e); end
    bus_idle();
    $display("watchdog: done, outputs=%b", outs);
  endtask
`else
  task automatic test_no_watchdog();
    logic [10:0] e;
    go_slave(1'b0, 4'b1111);
    tick(); tick(); e = 11'b0000_00_10_010;
    for (int i = 0; i < 12; i++) begin
      tick();
      checks++; if (outs !== e) begin errors++; $display("FAIL nowd_drive%0d got=%b exp=%b", i, outs, e); end
    end
    FCS_n = 1;
    tick(); tick(); e = V_IDLE;
    checks++; if (outs !== e) begin errors++; $display("FAIL nowd_idle got=%b exp=%b", outs, e); end
    bus_idle();
    $display("no watchdog: held in drive, outputs=%b", outs);
  endtask
`endif

  initial begin
    #100000;
    $display("FAIL sim_time_limit got=timeout exp=finish");
    $fatal(1, "simulation time limit");
  end

  initial begin
    test_reset();
    tick();
    test_slave_read();
    tick();
    test_back_to_back();
    tick();
    test_master_write();
    tick();
    test_setup_abort();
    tick();
    test_lane_zero();
    tick();
    test_async_reset();
    tick();
`ifdef BUFFER_SEQ_WATCHDOG_EN
    test_watchdog();
`else
    test_no_watchdog();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
